// File: rtl/key_fifo.sv
// -----------------------------------------------------------------------------
// key_fifo
//
// Key buffer between the USB-to-ASCII translator and the UART transmitter of
// the serial terminal. The translator cannot be stalled without losing CH9350
// bytes, so bursts of keys are absorbed here. Optionally every CR leaving the
// buffer is followed by an inserted LF.
//
// Ports:
//   i_clk            system clock (12 MHz)
//   i_rst_n          asynchronous active-low reset
//   i_key            key byte from the translator
//   i_key_valid      i_key is valid
//   o_key_ready      block accepts i_key (constant 1 when DROP_WHEN_FULL=1)
//   o_byte           byte to the UART transmitter
//   o_byte_valid     o_byte is valid
//   i_byte_ready     UART accepts o_byte
//   o_count          stored entries (a pending inserted LF is not counted)
//   o_overflow       sticky: at least one key was dropped while full
//   i_clear_overflow synchronous clear of o_overflow
//
// Parameters:
//   DEPTH            FIFO entries, power of two, at least 2
//   CRLF_EXPAND      1: each popped 0x0D is followed by an inserted 0x0A
//   DROP_WHEN_FULL   1: never back-pressure, discard keys arriving while full
//                    0: o_key_ready = !full
// -----------------------------------------------------------------------------
module key_fifo #(
    parameter int DEPTH          = 16,
    parameter bit CRLF_EXPAND    = 1'b1,
    parameter bit DROP_WHEN_FULL = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [7:0]                 i_key,
    input  logic                       i_key_valid,
    output logic                       o_key_ready,
    output logic [7:0]                 o_byte,
    output logic                       o_byte_valid,
    input  logic                       i_byte_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    input  logic                       i_clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic {
        ST_NORM = 1'b0,
        ST_LF   = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic            overflow_reg;
    logic [7:0]      mem [DEPTH];

    logic            full;
    logic            empty;
    logic            push;
    logic            drop;
    logic            pop;
    logic            xfer;
    logic [7:0]      head_byte;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    assign o_key_ready = DROP_WHEN_FULL ? 1'b1 : !full;

    // Full is judged on the registered pointers, so a pop in the same cycle
    // never frees a slot for the arriving key.
    assign push = i_key_valid && o_key_ready && !full;
    assign drop = DROP_WHEN_FULL && i_key_valid && full;

    assign head_byte = mem[rd_ptr_reg[AW-1:0]];

    // Output mux: in LF the inserted byte is presented regardless of the FIFO.
    always_comb begin
        o_byte       = head_byte;
        o_byte_valid = !empty;
        if (state_reg == ST_LF) begin
            o_byte       = CHAR_LF;
            o_byte_valid = 1'b1;
        end
    end

    assign xfer = o_byte_valid && i_byte_ready;

    // Next-state logic; only a transfer in NORM consumes a FIFO entry.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_NORM: begin
                if (xfer) begin
                    pop = 1'b1;
                    if (CRLF_EXPAND && (head_byte == CHAR_CR)) begin
                        state_next = ST_LF;
                    end
                end
            end
            ST_LF: begin
                if (xfer) begin
                    state_next = ST_NORM;
                end
            end
            default: begin
                state_next = ST_NORM;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_NORM;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (i_clear_overflow) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Storage is not reset; stale contents are never presented because
    // o_byte_valid follows the pointers.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= i_key;
        end
    end

    assign o_count    = wr_ptr_reg - rd_ptr_reg;
    assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_key_fifo.sv
// -----------------------------------------------------------------------------
// tb_key_fifo
//
// Directed bench for key_fifo. Two instances share one stimulus:
//   dut_a : DEPTH=16, CRLF_EXPAND=1, DROP_WHEN_FULL=1
//   dut_b : DEPTH=16, CRLF_EXPAND=0, DROP_WHEN_FULL=0
// Inputs change 1 time unit after a rising edge; outputs are checked 1 more
// unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_key_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] key;
    logic       key_valid;
    logic       byte_ready;
    logic       clear_ovf;

    logic       ready_a, valid_a, ovf_a;
    logic [7:0] byte_a;
    logic [4:0] count_a;
    logic       ready_b, valid_b, ovf_b;
    logic [7:0] byte_b;
    logic [4:0] count_b;

    int n_vec = 0;
    int n_err = 0;

    key_fifo #(.DEPTH(16), .CRLF_EXPAND(1'b1), .DROP_WHEN_FULL(1'b1)) dut_a (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_key            (key),
        .i_key_valid      (key_valid),
        .o_key_ready      (ready_a),
        .o_byte           (byte_a),
        .o_byte_valid     (valid_a),
        .i_byte_ready     (byte_ready),
        .o_count          (count_a),
        .o_overflow       (ovf_a),
        .i_clear_overflow (clear_ovf)
    );

    key_fifo #(.DEPTH(16), .CRLF_EXPAND(1'b0), .DROP_WHEN_FULL(1'b0)) dut_b (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_key            (key),
        .i_key_valid      (key_valid),
        .o_key_ready      (ready_b),
        .o_byte           (byte_b),
        .o_byte_valid     (valid_b),
        .i_byte_ready     (byte_ready),
        .o_count          (count_b),
        .o_overflow       (ovf_b),
        .i_clear_overflow (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_byte;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         idx;

    initial begin
        rst_n      = 1'b0;
        key        = 8'h00;
        key_valid  = 1'b0;
        byte_ready = 1'b0;
        clear_ovf  = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_count_a", 32'(count_a), 32'd0);
        chk("rst_ovf_a",   32'(ovf_a),   32'd0);
        chk("rst_ready_a", 32'(ready_a), 32'd1);
        chk("rst_ready_b", 32'(ready_b), 32'd1);
        chk("rst_valid_b", 32'(valid_b), 32'd0);
        rst_n = 1'b1;
        cyc();

        // ---------------- push 0x41, 0x42 with ready=1 ----------------
        key = 8'h41; key_valid = 1'b1; byte_ready = 1'b1; #1;
        chk("t1_valid_before_push", 32'(valid_a), 32'd0);
        cyc();
        key = 8'h42; #1;
        chk("t1_valid_a", 32'(valid_a), 32'd1);
        chk("t1_byte0_a", 32'(byte_a),  32'h41);
        chk("t1_count_a", 32'(count_a), 32'd1);
        cyc();
        key_valid = 1'b0; #1;
        chk("t1_byte1_a", 32'(byte_a),  32'h42);
        chk("t1_count1_a", 32'(count_a), 32'd1);
        chk("t1_byte1_b", 32'(byte_b),  32'h42);
        cyc();
        #1;
        chk("t1_empty_a", 32'(valid_a), 32'd0);
        chk("t1_count_end_a", 32'(count_a), 32'd0);
        chk("t1_empty_b", 32'(valid_b), 32'd0);

        // ---------------- CR expansion ----------------
        key = 8'h0D; key_valid = 1'b1; byte_ready = 1'b0; #1;
        cyc();
        key_valid = 1'b0; byte_ready = 1'b1; #1;
        chk("t2_cr_a",  32'(byte_a), 32'h0D);
        chk("t2_crv_a", 32'(valid_a), 32'd1);
        chk("t2_cr_b",  32'(byte_b), 32'h0D);
        cyc();
        key = 8'h61; key_valid = 1'b1; byte_ready = 1'b0; #1;
        chk("t2_lf_a",       32'(byte_a),  32'h0A);
        chk("t2_lfv_a",      32'(valid_a), 32'd1);
        chk("t2_lf_count_a", 32'(count_a), 32'd0);
        chk("t2_nolf_b",     32'(valid_b), 32'd0);
        cyc();
        key_valid = 1'b0; byte_ready = 1'b1; #1;
        chk("t2_lf_hold_a",   32'(byte_a),  32'h0A);
        chk("t2_lf_count1_a", 32'(count_a), 32'd1);
        chk("t2_61_b",        32'(byte_b),  32'h61);
        cyc();
        #1;
        chk("t2_61_a",   32'(byte_a),  32'h61);
        chk("t2_61v_a",  32'(valid_a), 32'd1);
        chk("t2_end_b",  32'(valid_b), 32'd0);
        cyc();
        byte_ready = 1'b0; #1;
        chk("t2_end_a",  32'(valid_a), 32'd0);
        chk("t2_endc_a", 32'(count_a), 32'd0);

        // ---------------- fill to full ----------------
        key_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            key = 8'h30 + 8'(i);
            #1;
            cyc();
        end
        key = 8'h40; #1;
        chk("t3_full_count_a", 32'(count_a), 32'd16);
        chk("t3_full_count_b", 32'(count_b), 32'd16);
        chk("t3_ready_a",      32'(ready_a), 32'd1);
        chk("t3_ready_b",      32'(ready_b), 32'd0);
        chk("t3_ovf_pre_a",    32'(ovf_a),   32'd0);
        chk("t3_head_a",       32'(byte_a),  32'h30);
        cyc();
        #1;
        chk("t3_ovf_a",    32'(ovf_a),   32'd1);
        chk("t3_ovf_b",    32'(ovf_b),   32'd0);
        chk("t3_count2_a", 32'(count_a), 32'd16);
        chk("t3_count2_b", 32'(count_b), 32'd16);
        // pop one while a key is waiting: still dropped/held that cycle
        key = 8'h50; byte_ready = 1'b1; #1;
        chk("t3_head_b", 32'(byte_b), 32'h30);
        cyc();
        byte_ready = 1'b0; #1;
        chk("t3_after_pop_a", 32'(count_a), 32'd15);
        chk("t3_after_pop_b", 32'(count_b), 32'd15);
        chk("t3_ready2_b",    32'(ready_b), 32'd1);
        cyc();
        key_valid = 1'b0; #1;
        chk("t3_refill_a", 32'(count_a), 32'd16);
        chk("t3_refill_b", 32'(count_b), 32'd16);
        chk("t3_ovf2_b",   32'(ovf_b),   32'd0);
        // clear alone, then clear together with a drop
        clear_ovf = 1'b1; cyc();
        clear_ovf = 1'b0; #1;
        chk("t3_clear_a", 32'(ovf_a), 32'd0);
        clear_ovf = 1'b1; key = 8'h51; key_valid = 1'b1; cyc();
        clear_ovf = 1'b0; key_valid = 1'b0; #1;
        chk("t3_clear_drop_a", 32'(ovf_a),   32'd1);
        chk("t3_clear_drop_c", 32'(count_a), 32'd16);
        chk("t3_clear_drop_b", 32'(ovf_b),   32'd0);
        // drain: 0x31..0x3F then 0x50
        byte_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_byte = (i < 15) ? (8'h31 + 8'(i)) : 8'h50;
            chk("t3_drain_a", 32'(byte_a), 32'(exp_byte));
            chk("t3_drain_b", 32'(byte_b), 32'(exp_byte));
            cyc();
            #1;
        end
        chk("t3_drained_a", 32'(valid_a), 32'd0);
        chk("t3_drainc_a",  32'(count_a), 32'd0);
        chk("t3_drained_b", 32'(valid_b), 32'd0);

        // ---------------- streaming across pointer wrap ----------------
        idx = 0;
        for (int c = 0; c < 400 && (idx < 40 || qa.size() > 0 || qb.size() > 0); c++) begin
            byte_ready = ($urandom_range(0, 3) != 0);
            key_valid  = (idx < 40) && (count_a < 5'd16);
            key        = 8'h60 + 8'(idx);
            #1;
            if (valid_a && byte_ready) begin
                if (qa.size() == 0) chk("t4_spurious_a", 32'(valid_a), 32'd0);
                else                chk("t4_order_a", 32'(byte_a), 32'(qa.pop_front()));
            end
            if (valid_b && byte_ready) begin
                if (qb.size() == 0) chk("t4_spurious_b", 32'(valid_b), 32'd0);
                else                chk("t4_order_b", 32'(byte_b), 32'(qb.pop_front()));
            end
            chk("t4_count_le16", 32'(count_a <= 5'd16), 32'd1);
            if (key_valid && ready_a) begin
                qa.push_back(key);
                idx++;
            end
            if (key_valid && ready_b) qb.push_back(key);
            cyc();
        end
        key_valid = 1'b0; byte_ready = 1'b0; #1;
        chk("t4_all_sent", 32'(idx), 32'd40);
        chk("t4_left_a",   32'(qa.size()), 32'd0);
        chk("t4_left_b",   32'(qb.size()), 32'd0);
        chk("t4_count_a",  32'(count_a), 32'd0);

        // ---------------- asynchronous reset while in LF ----------------
        key_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            key = (i == 0) ? 8'h0D : (8'h70 + 8'(i));
            #1;
            cyc();
        end
        key_valid = 1'b0; byte_ready = 1'b1; #1;
        chk("t5_cr_a", 32'(byte_a), 32'h0D);
        cyc();
        byte_ready = 1'b0; #1;
        chk("t5_lf_a",    32'(byte_a),  32'h0A);
        chk("t5_count_a", 32'(count_a), 32'd5);
        chk("t5_head_b",  32'(byte_b),  32'h71);
        chk("t5_count_b", 32'(count_b), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid_a", 32'(valid_a), 32'd0);
        chk("t5_rst_count_a", 32'(count_a), 32'd0);
        chk("t5_rst_ovf_a",   32'(ovf_a),   32'd0);
        chk("t5_rst_ready_a", 32'(ready_a), 32'd1);
        chk("t5_rst_valid_b", 32'(valid_b), 32'd0);
        chk("t5_rst_count_b", 32'(count_b), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
